// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC controller: pcsel encodings, the controller
// state enum and the per-cycle action decode used by the controller and the decoder.
package pc_ctrl_pkg;

  // PC select encodings. 2'b10 is reserved and never driven.
  localparam logic [1:0] PCSEL_INC = 2'b00;  // pc + 1
  localparam logic [1:0] PCSEL_REL = 2'b01;  // pc + 1 + ain
  localparam logic [1:0] PCSEL_ABS = 2'b11;  // ain

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // What the controller does to the PC in a given cycle.
  typedef enum logic [2:0] {
    ACT_INIT   = 3'd0,  // hold PC at 0 after reset
    ACT_HOLD   = 3'd1,  // stall: PC reloads itself
    ACT_TRAP   = 3'd2,  // interrupt entry
    ACT_ERET   = 3'd3,  // return from handler
    ACT_JUMP   = 3'd4,  // absolute jump
    ACT_BRANCH = 3'd5,  // taken relative branch
    ACT_INC    = 3'd6   // sequential fetch
  } action_t;

  // Redirects are the actions that bump the taken counter; holds never do.
  function automatic logic is_redirect(input action_t act);
    return (act == ACT_TRAP) || (act == ACT_ERET) ||
           (act == ACT_JUMP) || (act == ACT_BRANCH);
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc until the all-ones ceiling, then hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// PC controller for a single-cycle datapath: selects the next-PC source
// (increment, relative branch, absolute target or self-reload hold) and
// manages interrupt entry/return and a saturating redirect counter.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0040,
  parameter int unsigned INIT_HOLD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        br_en,
  input  logic        br_zero,
  input  logic        jmp_en,
  input  logic        eret,
  input  logic        stall_req,
  input  logic        irq,
  input  logic [31:0] br_off,
  input  logic [31:0] jmp_tgt,
  output logic [1:0]  pcsel,
  output logic [31:0] ain,
  output logic [31:0] epc,
  output logic        irq_ack,
  output logic        in_handler,
  output logic [15:0] taken_cnt
);

  // Last value of the init counter before moving to RUN.
  localparam logic [3:0] HOLD_LAST = 4'(INIT_HOLD - 1);

  state_t     state, state_nxt;
  logic [3:0] init_cnt;
  action_t    action;

  // Pick this cycle's action from state and inputs in priority order.
  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    action = ACT_INC;
    if (state == ST_INIT) begin
      action = ACT_INIT;
    end else if (irq && !in_handler && !stall_req) begin
      action = ACT_TRAP;
    end else if (stall_req) begin
      action = ACT_HOLD;
    end else if (eret && in_handler) begin
      action = ACT_ERET;
    end else if (jmp_en) begin
      action = ACT_JUMP;
    end else if (br_en && br_zero) begin
      action = ACT_BRANCH;
    end
  end

  // Map the action onto the PC select and its paired operand.
  always_comb begin
    pcsel = PCSEL_INC;
    ain   = '0;
    unique case (action)
      ACT_INIT:   begin pcsel = PCSEL_ABS; ain = '0;       end
      ACT_HOLD:   begin pcsel = PCSEL_ABS; ain = pc;       end
      ACT_TRAP:   begin pcsel = PCSEL_ABS; ain = TRAP_VEC; end
      ACT_ERET:   begin pcsel = PCSEL_ABS; ain = epc;      end
      ACT_JUMP:   begin pcsel = PCSEL_ABS; ain = jmp_tgt;  end
      ACT_BRANCH: begin pcsel = PCSEL_REL; ain = br_off;   end
      default:    begin pcsel = PCSEL_INC; ain = '0;       end
    endcase
  end

  // Next state: INIT counts out its hold, RUN/STALL follow stall_req.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT:  if (init_cnt == HOLD_LAST) state_nxt = ST_RUN;
      ST_RUN,
      ST_STALL: state_nxt = stall_req ? ST_STALL : ST_RUN;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // State register and init hold counter.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT && init_cnt != HOLD_LAST) begin
        init_cnt <= init_cnt + 4'd1;
      end
    end
  end

  // Handler context: save return address on trap entry, clear on return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epc        <= '0;
      in_handler <= 1'b0;
      irq_ack    <= 1'b0;
    end else begin
      irq_ack <= (action == ACT_TRAP);
      if (action == ACT_TRAP) begin
        epc        <= pc;
        in_handler <= 1'b1;
      end else if (action == ACT_ERET) begin
        in_handler <= 1'b0;
      end
    end
  end

  sat_cnt #(
    .WIDTH(16)
  ) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (is_redirect(action)),
    .count (taken_cnt)
  );

endmodule
